router_pkt_tx: RTL

- Packet source for the 1x3 router's input port; it is the transmit end of the router packet protocol.
- Accepts a packet request (destination address and length), buffers the payload bytes from an upstream byte stream, then serialises them onto `data_out`/`packet_valid`:
  - header byte, then payload bytes, then parity byte;
  - obeys the router's `busy` back-pressure.
- Samples the router's `err` after each packet and reports per-packet status.
- Used as the stimulus and bridge block in front of the router top.

---
 rtl/router_pkg.sv | 31 +++
 rtl/router_tx_buf.sv | 30 +++
 rtl/router_pkt_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_pkg;

  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned LEN_W     = 6;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BUF_DEPTH = 64;

  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_HEADER,
    TX_PAYLOAD,
    TX_PARITY,
    TX_GAP
  } tx_state_e;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } tx_req_t;

  // Header byte layout on the wire: length in [7:2], destination in [1:0].
  function automatic logic [DATA_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload staging buffer: synchronous write at the running write count, combinational read.
module router_tx_buf
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LEN_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [LEN_W-1:0]  wr_cnt
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];

  // Storage carries no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      wr_cnt <= '0;
    else if (clr)   wr_cnt <= '0;
    else if (wr_en) wr_cnt <= wr_cnt + LEN_W'(1);
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Transmit end of the router packet protocol: buffers a payload, then sends header/payload/parity.
// Optional ROUTER_TX_PARITY_CORRUPT_EN adds corrupt_parity to invert the transmitted parity byte.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 63,
  parameter int unsigned GAP_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_err,
  input  logic [DATA_W-1:0] pld_data,
  input  logic              pld_valid,
  output logic              pld_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              packet_valid,
  input  logic              busy,
  input  logic              err,
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
  input  logic              corrupt_parity,
`endif
  output logic              pkt_done,
  output logic              pkt_err
);

  localparam int unsigned GAP_W = 4;

  tx_state_e         state_q, state_d;
  tx_req_t           req_q, req_d;
  logic [DATA_W-1:0] parity_q, parity_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              req_ready_d, req_err_d, pld_ready_d;
  logic              packet_valid_d, pkt_done_d, pkt_err_d;
  logic [DATA_W-1:0] data_out_d;

  logic              wr_en, buf_clr, req_bad, last_beat;
  logic [LEN_W-1:0]  wr_cnt, rd_addr;
  logic [DATA_W-1:0] rd_data, header, parity_tx;

`ifdef ROUTER_TX_PARITY_CORRUPT_EN
  logic corrupt_q, corrupt_d;
  assign parity_tx = parity_q ^ {DATA_W{corrupt_q}};
`else
  assign parity_tx = parity_q;
`endif

  router_tx_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .wr_en   (wr_en),
    .wr_data (pld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_cnt  (wr_cnt)
  );

  assign header    = pack_header(req_q.len, req_q.addr);
  assign buf_clr   = (state_q == TX_IDLE);
  assign wr_en     = (state_q == TX_LOAD) && pld_valid && pld_ready;
  assign last_beat = wr_en && ((wr_cnt + LEN_W'(1)) == req_q.len);
  assign req_bad   = (req_addr == ADDR_ILLEGAL) || (req_len == '0) || (32'(req_len) > MAX_LEN);
  // Prefetch address for the byte that goes out after the current consume.
  assign rd_addr   = (state_q == TX_HEADER) ? '0 : idx_q + LEN_W'(1);

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    parity_d       = parity_q;
    idx_d          = idx_q;
    gap_d          = gap_q;
    req_ready_d    = req_ready;
    req_err_d      = 1'b0;
    pld_ready_d    = pld_ready;
    data_out_d     = data_out;
    packet_valid_d = packet_valid;
    pkt_done_d     = 1'b0;
    pkt_err_d      = pkt_err;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
    corrupt_d      = corrupt_q;
`endif

    case (state_q)
      TX_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          req_d = '{len: req_len, addr: req_addr};
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
          corrupt_d = corrupt_parity;
`endif
          if (req_bad) begin
            req_err_d = 1'b1;
          end else begin
            state_d     = TX_LOAD;
            req_ready_d = 1'b0;
            pld_ready_d = 1'b1;
            parity_d    = pack_header(req_len, req_addr);
          end
        end
      end

      TX_LOAD: begin
        if (wr_en) begin
          parity_d = parity_q ^ pld_data;
          if (last_beat) begin
            state_d        = TX_HEADER;
            pld_ready_d    = 1'b0;
            data_out_d     = header;
            packet_valid_d = 1'b1;
          end
        end
      end

      TX_HEADER: begin
        if (!busy) begin
          state_d    = TX_PAYLOAD;
          idx_d      = '0;
          data_out_d = rd_data;
        end
      end

      TX_PAYLOAD: begin
        if (!busy) begin
          if (idx_q == req_q.len - LEN_W'(1)) begin
            state_d        = TX_PARITY;
            data_out_d     = parity_tx;
            packet_valid_d = 1'b0;
          end else begin
            idx_d      = idx_q + LEN_W'(1);
            data_out_d = rd_data;
          end
        end
      end

      TX_PARITY: begin
        if (!busy) begin
          state_d = TX_GAP;
          gap_d   = '0;
        end
      end

      TX_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d     = TX_IDLE;
          pkt_done_d  = 1'b1;
          pkt_err_d   = err;
          req_ready_d = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= TX_IDLE;
      req_q        <= '0;
      parity_q     <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      req_ready    <= 1'b1;
      req_err      <= 1'b0;
      pld_ready    <= 1'b0;
      data_out     <= '0;
      packet_valid <= 1'b0;
      pkt_done     <= 1'b0;
      pkt_err      <= 1'b0;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
      corrupt_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      parity_q     <= parity_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      req_ready    <= req_ready_d;
      req_err      <= req_err_d;
      pld_ready    <= pld_ready_d;
      data_out     <= data_out_d;
      packet_valid <= packet_valid_d;
      pkt_done     <= pkt_done_d;
      pkt_err      <= pkt_err_d;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
      corrupt_q    <= corrupt_d;
`endif
    end
  end

endmodule
